// File: rtl/alu_mul_seq_if.sv
// Bundle between the multiply sequencer and the EXE stage: pipeline request, shared ALU
// path and completion/status outputs.
interface alu_mul_seq_if #(
    parameter int unsigned DATA_LEN = 32
);
    logic                start;
    logic                accumulate;
    logic                set_flags;
    logic                flush;
    logic [DATA_LEN-1:0] op_rm;
    logic [DATA_LEN-1:0] op_rs;
    logic [DATA_LEN-1:0] op_rn;
    logic [DATA_LEN-1:0] alu_res;

    logic                alu_own;
    logic [3:0]          alu_exe_cmd;
    logic [DATA_LEN-1:0] alu_val1;
    logic [DATA_LEN-1:0] alu_val2;
    logic                alu_carry_in;
    logic                busy;
    logic                done;
    logic [DATA_LEN-1:0] result;
    logic                n_flag;
    logic                z_flag;
    logic                flags_we;

    // Sequencer side.
    modport slave (
        input  start, accumulate, set_flags, flush, op_rm, op_rs, op_rn, alu_res,
        output alu_own, alu_exe_cmd, alu_val1, alu_val2, alu_carry_in, busy, done, result,
        output n_flag, z_flag, flags_we
    );

    // Pipeline / ALU side.
    modport master (
        output start, accumulate, set_flags, flush, op_rm, op_rs, op_rn, alu_res,
        input  alu_own, alu_exe_cmd, alu_val1, alu_val2, alu_carry_in, busy, done, result,
        input  n_flag, z_flag, flags_we
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-and-add MUL/MLA sequencer that borrows the EXE-stage ALU, issuing one ADD per
// multiplier bit and stalling the pipeline while it works.
module alu_mul_seq #(
    parameter int unsigned DATA_LEN   = 32,
    parameter bit          EARLY_TERM = 1'b1
) (
    input logic          clk,
    input logic          rst,
    alu_mul_seq_if.slave bus
);
    localparam int unsigned CntW = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;
    localparam logic [3:0]  CmdAdd = 4'b0010;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e              state_q, state_d;
    logic [DATA_LEN-1:0] mcand_q, mplier_q, acc_q, result_q;
    logic [CntW-1:0]     cnt_q;
    logic                s_q;
    logic                cnt_last, last_step, accept, done_int;

    assign cnt_last  = (cnt_q == CntW'(DATA_LEN - 1));
    assign last_step = cnt_last || (EARLY_TERM && ((mplier_q >> 1) == '0));
    assign accept    = (state_q == StIdle) && bus.start && !bus.flush;
    assign done_int  = (state_q == StDone) && !bus.flush;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = (EARLY_TERM && (bus.op_rs == '0)) ? StDone : StRun;
                end
            end
            StRun:   if (last_step) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (bus.flush) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            s_q      <= 1'b0;
        end else begin
            if (accept) begin
                mcand_q  <= bus.op_rm;
                mplier_q <= bus.op_rs;
                acc_q    <= bus.accumulate ? bus.op_rn : '0;
                cnt_q    <= '0;
                s_q      <= bus.set_flags;
            end else if (state_q == StRun) begin
                // ALU carry-out is ignored: the product is modulo 2^DATA_LEN.
                acc_q    <= bus.alu_res;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                if (!cnt_last) begin
                    cnt_q <= cnt_q + CntW'(1);
                end
            end
            if (done_int) begin
                result_q <= acc_q;
            end
        end
    end

    always_comb begin
        bus.alu_own      = 1'b0;
        bus.alu_exe_cmd  = 4'b0000;
        bus.alu_val1     = '0;
        bus.alu_val2     = '0;
        bus.alu_carry_in = 1'b0;
        bus.busy         = (state_q != StIdle);
        bus.done         = done_int;
        bus.result       = done_int ? acc_q : result_q;
        bus.n_flag       = done_int & acc_q[DATA_LEN-1];
        bus.z_flag       = done_int & (acc_q == '0);
        bus.flags_we     = done_int & s_q;
        if (state_q == StRun) begin
            bus.alu_own     = 1'b1;
            bus.alu_exe_cmd = CmdAdd;
            bus.alu_val1    = acc_q;
            bus.alu_val2    = mplier_q[0] ? mcand_q : '0;
        end
    end
endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle multiply sequencer that borrows the shared execute-stage ALU to run ARM MUL (Rd = Rm*Rs) and MLA (Rd = Rm*Rs + Rn), lower DATA_LEN bits only.
- Uses shift-and-add: one multiplier bit per cycle, each step issued to the ALU as an ADD command.
- Sits beside the ALU in EXE. While active it owns the ALU input mux via alu_own and stalls the pipeline via busy.

Parameters:
- DATA_LEN, 32, datapath width (operands, result, ALU interface).
- EARLY_TERM, 1, 1 = stop once the remaining multiplier bits are all zero; 0 = always run DATA_LEN steps.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
- start  input  1  request; accepted only in IDLE.
- accumulate  input  1  sampled with start; 1 = MLA, 0 = MUL.
- set_flags  input  1  sampled with start; S bit.
- flush  input  1  synchronous abort (branch/exception flush).
- op_rm  input  DATA_LEN  multiplicand, sampled with start.
- op_rs  input  DATA_LEN  multiplier, sampled with start.
- op_rn  input  DATA_LEN  accumulate addend, sampled with start.
- alu_res  input  DATA_LEN  ALU result (combinational return).
- alu_own  output  1  1 = EXE mux must route the alu_* outputs below to the ALU.
- alu_exe_cmd  output  4  ALU command.
- alu_val1  output  DATA_LEN  ALU operand 1.
- alu_val2  output  DATA_LEN  ALU operand 2.
- alu_carry_in  output  1  ALU carry in; always 0.
- busy  output  1  stall request to the pipeline.
- done  output  1  one-cycle completion pulse.
- result  output  DATA_LEN  product; held until the next accepted start.
- n_flag  output  1  result[DATA_LEN-1], valid while done.
- z_flag  output  1  result == 0, valid while done.
- flags_we  output  1  done & latched set_flags; status register write enable.

Behaviour:
- States: IDLE, RUN, DONE. busy = (state != IDLE). alu_own = (state == RUN).
- Reset (rst = 0 at a clock edge): state IDLE. All outputs 0 (alu_exe_cmd = 4'b0000, result = 0). All internal registers cleared. Reset overrides every other input, including in mid-operation.
- IDLE with start = 1 (accept):
  - mcand <= op_rm; mplier <= op_rs; acc <= accumulate ? op_rn : 0; step count <= 0; S bit latched.
  - Next state RUN. Exception: if EARLY_TERM = 1 and op_rs == 0, next state DONE with result = acc initial value.
- RUN, every cycle:
  - alu_exe_cmd = 4'b0010 (ADD); alu_val1 = acc; alu_val2 = mplier[0] ? mcand : 0; alu_carry_in = 0.
  - On the clock edge: acc <= alu_res; mcand <= mcand << 1; mplier <= mplier >> 1; count++.
  - The ALU carry-out is ignored; arithmetic is modulo 2^DATA_LEN.
- RUN exit:
  - EARLY_TERM = 1: go to DONE when (mplier >> 1) == 0 or count == DATA_LEN-1.
  - EARLY_TERM = 0: go to DONE when count == DATA_LEN-1.
  - RUN length k = (index of highest set bit of Rs) + 1 with early termination, otherwise DATA_LEN.
- DONE: single cycle. done = 1; result = acc; flags_we = latched S. Next state IDLE.
- Latency: start accepted in cycle T gives done in cycle T+1+k (T+1 for Rs = 0 with early termination).
- Outside RUN: alu_exe_cmd = 0, alu_val1 = 0, alu_val2 = 0.
- start while busy is ignored; no queueing. start in the same cycle done is high is also ignored; it is accepted the following cycle in IDLE.
- flush = 1 in any state: next state IDLE. done and flags_we stay 0 in that cycle and afterwards. result keeps its previous value. Same-cycle flush and start in IDLE: flush wins, start is dropped.
- Width of the step counter: clog2(DATA_LEN) bits, with no wrap-around beyond DATA_LEN-1.

Test Plan:
- MUL with Rm = 3, Rs = 5 (EARLY_TERM = 1) -> 3 RUN cycles, alu_own high for 3 cycles, done at T+4, result = 15, flags_we = 0.
- MLA with Rm = 7, Rs = 9, Rn = 100, set_flags = 1 -> done at T+5, result = 163, n_flag = 0, z_flag = 0, flags_we = 1 for one cycle.
- Rm = 0xFFFFFFFF, Rs = 0xFFFFFFFF, set_flags = 1 -> 32 RUN cycles, result = 0x00000001. Then Rm = 0x80000000, Rs = 2 -> result = 0, z_flag = 1.
- Rs = 0 with accumulate = 1, Rn = 0x1234 -> no RUN cycles, done at T+1, result = 0x1234, alu_own never asserted.
- Flush at RUN step 2 of Rs = 0xFF -> IDLE next cycle, done never pulses, result unchanged. A second start pulsed during RUN is ignored.
- rst = 0 mid-RUN -> all outputs 0 at the next edge. A fresh start after release completes correctly (6*6 = 36).
